tt_lock_detector: RTL and testbench

TT_LOCK_DETECTOR -- requirements
Module: tt_lock_detector

---
 rtl/tt_dpll_pkg.sv | 29 ++
 rtl/tt_lock_detector.sv | 209 ++++++++++++++++++++
 tb/tb_tt_lock_detector.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_dpll_pkg.sv
// -----------------------------------------------------------------------------
// tt_dpll_pkg
// Shared definitions for the DPLL blocks: lock-detector FSM state encoding and
// the default lock/unlock window thresholds.
// -----------------------------------------------------------------------------
package tt_dpll_pkg;

   // Lock-detector FSM states. The encoding is visible on o_state and in the
   // scan chain, so the numeric values are fixed.
   typedef enum logic [1:0] {
      ST_UNLOCKED  = 2'd0,
      ST_ACQUIRING = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_SLIPPING  = 2'd3
   } lock_state_e;

   // Consecutive clean windows needed to declare lock.
   localparam int LOCK_COUNT_DEF   = 16;
   // Consecutive errored windows needed to drop lock.
   localparam int UNLOCK_COUNT_DEF = 4;
   // Width of the good/bad window counters.
   localparam int LOCK_CNT_W_DEF   = 8;

   // True for the states in which the loop is reported as locked.
   function automatic logic state_is_locked(input lock_state_e st);
      return (st == ST_LOCKED) || (st == ST_SLIPPING);
   endfunction

endpackage : tt_dpll_pkg

// File: rtl/tt_lock_detector.sv
// -----------------------------------------------------------------------------
// tt_lock_detector
// Declares DPLL lock after LOCK_COUNT consecutive clean divided-clock windows
// and drops it after UNLOCK_COUNT consecutive errored windows. A window ends on
// the rising edge of i_clk_div (sampled in the i_clk_gen domain); a window is
// errored if the PFD produced any up/down pulse during it, including on the
// boundary cycle itself.
//
// Ports
//   i_clk_gen      generated DPLL clock (only clock)
//   i_rst_n        asynchronous active-low reset
//   i_clk_div      divided feedback clock, synchronous to i_clk_gen
//   i_up, i_down   PFD pulses; either (or both) marks the window errored
//   i_clear_sticky single-cycle clear of o_lock_lost
//   o_locked       registered lock indicator (LOCKED or SLIPPING)
//   o_lock_lost    sticky: lock was held and then lost
//   o_state        registered FSM state (debug / status)
//   i_scan_en      scan shift enable, suspends all functional updates
//   i_scan_in      scan serial input
//   o_scan_out     scan serial output (= o_lock_lost)
//
// Scan chain, from i_scan_in to o_scan_out:
//   clk_div_q, err_acc, state[1:0], good_cnt[CNT_W-1:0], bad_cnt[CNT_W-1:0],
//   o_locked, o_lock_lost
//
// Legal parameter ranges: LOCK_COUNT 2..255, UNLOCK_COUNT 1..255, and both
// must fit in CNT_W bits.
// -----------------------------------------------------------------------------
module tt_lock_detector
   import tt_dpll_pkg::*;
#(
   parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
   parameter int UNLOCK_COUNT = UNLOCK_COUNT_DEF,
   parameter int CNT_W        = LOCK_CNT_W_DEF
) (
   input  logic       i_clk_gen,
   input  logic       i_rst_n,
   input  logic       i_clk_div,
   input  logic       i_up,
   input  logic       i_down,
   input  logic       i_clear_sticky,
   output logic       o_locked,
   output logic       o_lock_lost,
   output logic [1:0] o_state,
   input  logic       i_scan_en,
   input  logic       i_scan_in,
   output logic       o_scan_out
);

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] LOCK_CMP   = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] UNLOCK_CMP = CNT_W'(UNLOCK_COUNT);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic              r_clk_div_q;   // i_clk_div delayed one cycle
   logic              r_err_acc;     // any PFD pulse seen earlier in this window
   lock_state_e       r_state;
   logic [CNT_W-1:0]  r_good_cnt;    // consecutive clean windows while acquiring
   logic [CNT_W-1:0]  r_bad_cnt;     // consecutive errored windows while locked
   logic              r_locked;
   logic              r_lock_lost;

   // ---------------------------------------------------------------------------
   // Window decode
   // ---------------------------------------------------------------------------
   logic              w_boundary;
   logic              w_err_now;
   logic              w_win_err;
   logic [CNT_W-1:0]  w_good_inc;
   logic [CNT_W-1:0]  w_bad_inc;

   assign w_boundary = i_clk_div & ~r_clk_div_q;
   // Simultaneous up and down is still an error: the loop is not quiet.
   assign w_err_now  = i_up | i_down;
   // A pulse on the boundary cycle belongs to the window that is closing.
   assign w_win_err  = r_err_acc | w_err_now;

   // Saturating increments; counters park at all-ones instead of wrapping.
   assign w_good_inc = (r_good_cnt == CNT_MAX) ? r_good_cnt : r_good_cnt + 1'b1;
   assign w_bad_inc  = (r_bad_cnt  == CNT_MAX) ? r_bad_cnt  : r_bad_cnt  + 1'b1;

   // ---------------------------------------------------------------------------
   // Sequential logic: scan shift or functional update.
   // Every transition branch also writes r_locked so that the registered lock
   // indicator follows the state on the same edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_div_q <= 1'b0;
         r_err_acc   <= 1'b0;
         r_state     <= ST_UNLOCKED;
         r_good_cnt  <= '0;
         r_bad_cnt   <= '0;
         r_locked    <= 1'b0;
         r_lock_lost <= 1'b0;
      end else if (i_scan_en) begin
         // One-position shift through the whole chain; nothing functional moves.
         r_clk_div_q <= i_scan_in;
         r_err_acc   <= r_clk_div_q;
         r_state     <= lock_state_e'({r_err_acc, r_state[1]});
         r_good_cnt  <= {r_state[0], r_good_cnt[CNT_W-1:1]};
         r_bad_cnt   <= {r_good_cnt[0], r_bad_cnt[CNT_W-1:1]};
         r_locked    <= r_bad_cnt[0];
         r_lock_lost <= r_locked;
      end else begin
         r_clk_div_q <= i_clk_div;

         if (w_boundary) begin
            r_err_acc <= 1'b0;
         end else if (w_err_now) begin
            r_err_acc <= 1'b1;
         end

         // Clear first so that a loss event below overrides it in the same cycle.
         if (i_clear_sticky) begin
            r_lock_lost <= 1'b0;
         end

         if (w_boundary) begin
            case (r_state)
               ST_UNLOCKED: begin
                  if (w_win_err) begin
                     r_good_cnt <= '0;
                  end else begin
                     r_state    <= ST_ACQUIRING;
                     r_good_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                  end
                  r_locked <= 1'b0;
               end

               ST_ACQUIRING: begin
                  if (w_win_err) begin
                     r_state    <= ST_UNLOCKED;
                     r_good_cnt <= '0;
                     r_locked   <= 1'b0;
                  end else begin
                     r_good_cnt <= w_good_inc;
                     if (w_good_inc == LOCK_CMP) begin
                        r_state   <= ST_LOCKED;
                        r_bad_cnt <= '0;
                        r_locked  <= 1'b1;
                     end else begin
                        r_locked  <= 1'b0;
                     end
                  end
               end

               ST_LOCKED: begin
                  if (w_win_err) begin
                     if (UNLOCK_COUNT == 1) begin
                        // A single errored window is enough to lose lock.
                        r_state     <= ST_UNLOCKED;
                        r_good_cnt  <= '0;
                        r_bad_cnt   <= '0;
                        r_locked    <= 1'b0;
                        r_lock_lost <= 1'b1;
                     end else begin
                        r_state   <= ST_SLIPPING;
                        r_bad_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                        r_locked  <= 1'b1;
                     end
                  end else begin
                     r_locked <= 1'b1;
                  end
               end

               ST_SLIPPING: begin
                  if (w_win_err) begin
                     if (w_bad_inc == UNLOCK_CMP) begin
                        r_state     <= ST_UNLOCKED;
                        r_good_cnt  <= '0;
                        r_bad_cnt   <= '0;
                        r_locked    <= 1'b0;
                        r_lock_lost <= 1'b1;
                     end else begin
                        r_bad_cnt <= w_bad_inc;
                        r_locked  <= 1'b1;
                     end
                  end else begin
                     // One clean window restores full lock.
                     r_state   <= ST_LOCKED;
                     r_bad_cnt <= '0;
                     r_locked  <= 1'b1;
                  end
               end

               default: begin
                  r_state  <= ST_UNLOCKED;
                  r_locked <= 1'b0;
               end
            endcase
         end else begin
            // Keeps o_locked consistent with the state even after a scan load.
            r_locked <= state_is_locked(r_state);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_locked    = r_locked;
   assign o_lock_lost = r_lock_lost;
   assign o_state     = r_state;
   assign o_scan_out  = r_lock_lost;

endmodule : tt_lock_detector

// File: tb/tb_tt_lock_detector.sv
// -----------------------------------------------------------------------------
// tb_tt_lock_detector
// Directed bench for tt_lock_detector with a window-level reference model.
// Each driven window is three i_clk_gen cycles: two with i_clk_div low and a
// final boundary cycle with i_clk_div high.
// -----------------------------------------------------------------------------
module tb_tt_lock_detector;

   localparam int LOCK_N   = 16;
   localparam int UNLOCK_N = 4;
   localparam int CW       = 8;
   localparam int CHAIN_N  = 2 * CW + 6;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_div = 1'b0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       clear_sticky = 1'b0;
   logic       scan_en = 1'b0;
   logic       scan_in = 1'b0;
   logic       locked;
   logic       lock_lost;
   logic [1:0] state;
   logic       scan_out;

   always #5 clk = ~clk;

   tt_lock_detector #(
      .LOCK_COUNT   (LOCK_N),
      .UNLOCK_COUNT (UNLOCK_N),
      .CNT_W        (CW)
   ) dut (
      .i_clk_gen      (clk),
      .i_rst_n        (rst_n),
      .i_clk_div      (clk_div),
      .i_up           (up),
      .i_down         (down),
      .i_clear_sticky (clear_sticky),
      .o_locked       (locked),
      .o_lock_lost    (lock_lost),
      .o_state        (state),
      .i_scan_en      (scan_en),
      .i_scan_in      (scan_in),
      .o_scan_out     (scan_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: tracks runs of clean / errored windows rather than an
   // explicit state register. Lock is gained after LOCK_N clean windows in a
   // row and lost after UNLOCK_N errored windows in a row.
   // ---------------------------------------------------------------------------
   bit m_prev_div;
   bit m_err_seen;
   bit m_locked;
   int m_clean_run;
   int m_err_run;
   bit m_lost;

   always @(posedge clk or negedge rst_n) begin
      bit bnd;
      bit werr;
      bit lost_ev;
      if (!rst_n) begin
         m_prev_div  = 1'b0;
         m_err_seen  = 1'b0;
         m_locked    = 1'b0;
         m_clean_run = 0;
         m_err_run   = 0;
         m_lost      = 1'b0;
      end else if (!scan_en) begin
         bnd     = clk_div && !m_prev_div;
         werr    = m_err_seen || up || down;
         lost_ev = 1'b0;
         if (bnd) begin
            if (!m_locked) begin
               if (werr) m_clean_run = 0;
               else begin
                  m_clean_run++;
                  if (m_clean_run >= LOCK_N) begin
                     m_locked  = 1'b1;
                     m_err_run = 0;
                  end
               end
            end else begin
               if (werr) begin
                  m_err_run++;
                  if (m_err_run >= UNLOCK_N) begin
                     m_locked    = 1'b0;
                     m_clean_run = 0;
                     lost_ev     = 1'b1;
                  end
               end else begin
                  m_err_run = 0;
               end
            end
            m_err_seen = 1'b0;
         end else if (up || down) begin
            m_err_seen = 1'b1;
         end
         if (lost_ev) m_lost = 1'b1;
         else if (clear_sticky) m_lost = 1'b0;
         m_prev_div = clk_div;
      end
   end

   function automatic logic [1:0] model_state();
      if (!m_locked) return (m_clean_run == 0) ? 2'd0 : 2'd1;
      return (m_err_run == 0) ? 2'd2 : 2'd3;
   endfunction

   // Compare process: every functional cycle, away from the active edge.
   always @(negedge clk) begin
      if (!scan_en) begin
         chk("state_vs_model", {30'd0, state}, {30'd0, model_state()});
         chk("locked_vs_model", {31'd0, locked}, {31'd0, m_locked});
         chk("lost_vs_model", {31'd0, lock_lost}, {31'd0, m_lost});
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // err_pos: -1 for a clean window, else cycle 0..2 carrying the pulse(s).
   task automatic window(input int err_pos, input bit u, input bit d, input bit clr_at_bnd);
      for (int c = 0; c < 3; c++) begin
         clk_div      = (c == 2);
         up           = u && (c == err_pos);
         down         = d && (c == err_pos);
         clear_sticky = clr_at_bnd && (c == 2);
         step();
      end
      up           = 1'b0;
      down         = 1'b0;
      clear_sticky = 1'b0;
   endtask

   task automatic clean_windows(input int n);
      for (int i = 0; i < n; i++) window(-1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      clk_div = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_clear();
      clk_div      = 1'b0;
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   logic [CHAIN_N-1:0] pat;
   logic [CHAIN_N-1:0] snap;
   logic [CHAIN_N-1:0] back;

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_lost", {31'd0, lock_lost}, 32'd0);
      chk("rst_scan_out", {31'd0, scan_out}, 32'd0);
      rst_n = 1'b1;

      // 16 clean windows: 0 -> 1 -> 2, o_locked rises just after the 16th.
      for (int w = 1; w <= LOCK_N; w++) begin
         window(-1, 1'b0, 1'b0, 1'b0);
         if (w == 1) chk("acq_after_1", {30'd0, state}, 32'd1);
         if (w == 15) begin
            chk("acq_after_15", {30'd0, state}, 32'd1);
            chk("unlocked_after_15", {31'd0, locked}, 32'd0);
         end
      end
      chk("locked_state_16", {30'd0, state}, 32'd2);
      chk("locked_16", {31'd0, locked}, 32'd1);

      // 3 errored windows (up, down, both) then a clean one: stays locked.
      window(0, 1'b1, 1'b0, 1'b0);
      chk("slip_1", {30'd0, state}, 32'd3);
      window(1, 1'b0, 1'b1, 1'b0);
      window(2, 1'b1, 1'b1, 1'b0);
      chk("slip_3_locked", {31'd0, locked}, 32'd1);
      clean_windows(1);
      chk("slip_recover", {30'd0, state}, 32'd2);
      chk("slip_no_lost", {31'd0, lock_lost}, 32'd0);

      // 4 errored windows: lock lost, then sticky clear.
      for (int w = 0; w < UNLOCK_N; w++) window(1, 1'b1, 1'b0, 1'b0);
      chk("lost_locked", {31'd0, locked}, 32'd0);
      chk("lost_flag", {31'd0, lock_lost}, 32'd1);
      chk("lost_state", {30'd0, state}, 32'd0);
      pulse_clear();
      chk("lost_cleared", {31'd0, lock_lost}, 32'd0);

      // Relock, then lose lock with a clear on the very boundary: set wins.
      clean_windows(LOCK_N);
      for (int w = 0; w < UNLOCK_N - 1; w++) window(0, 1'b0, 1'b1, 1'b0);
      window(0, 1'b0, 1'b1, 1'b1);
      chk("set_beats_clear", {31'd0, lock_lost}, 32'd1);
      pulse_clear();
      chk("lost_cleared_2", {31'd0, lock_lost}, 32'd0);

      // 15 clean windows, up pulse in the 16th: back to UNLOCKED, count restarts.
      clean_windows(LOCK_N - 1);
      window(1, 1'b1, 1'b0, 1'b0);
      chk("acq_abort_state", {30'd0, state}, 32'd0);
      chk("acq_abort_locked", {31'd0, locked}, 32'd0);
      clean_windows(LOCK_N - 1);
      chk("acq_restart_15", {30'd0, state}, 32'd1);
      clean_windows(1);
      chk("acq_restart_16", {30'd0, state}, 32'd2);

      // Both up and down exactly on the boundary cycle is an error.
      window(2, 1'b1, 1'b1, 1'b0);
      chk("both_on_bnd", {30'd0, state}, 32'd3);
      clean_windows(1);
      chk("both_recover", {30'd0, state}, 32'd2);

      // Scan: shift a pattern in while reading the held state out, then shift
      // the captured state back in while the pattern emerges.
      idle(2);
      pat     = CHAIN_N'({$urandom, $urandom});
      scan_en = 1'b1;
      for (int i = 0; i < CHAIN_N; i++) begin
         snap[i] = scan_out;
         scan_in = pat[i];
         clk_div = 1'(($urandom_range(0, 1)));
         up      = 1'(($urandom_range(0, 1)));
         step();
      end
      for (int i = 0; i < CHAIN_N; i++) begin
         back[i] = scan_out;
         scan_in = snap[i];
         step();
      end
      scan_en = 1'b0;
      clk_div = 1'b0;
      up      = 1'b0;
      chk("scan_pattern", back, pat);
      chk("scan_snap_lost", {31'd0, snap[0]}, 32'd0);
      chk("scan_snap_locked", {31'd0, snap[1]}, 32'd1);
      chk("scan_snap_bad", {24'd0, snap[9:2]}, 32'd0);
      chk("scan_snap_state", {30'd0, snap[19:18]}, 32'd2);
      chk("scan_snap_err_acc", {31'd0, snap[20]}, 32'd0);
      chk("scan_snap_div_q", {31'd0, snap[21]}, 32'd0);
      chk("scan_restore_state", {30'd0, state}, 32'd2);
      chk("scan_restore_locked", {31'd0, locked}, 32'd1);

      // Functional operation continues from the restored state.
      window(0, 1'b1, 1'b0, 1'b0);
      chk("post_scan_slip", {30'd0, state}, 32'd3);
      clean_windows(1);
      chk("post_scan_relock", {30'd0, state}, 32'd2);

      // Reset mid-window discards the partial (errored) window.
      clk_div = 1'b0;
      up      = 1'b1;
      step();
      up    = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("async_rst_state", {30'd0, state}, 32'd0);
      chk("async_rst_locked", {31'd0, locked}, 32'd0);
      step();
      rst_n = 1'b1;
      clean_windows(1);
      chk("rst_partial_discard", {30'd0, state}, 32'd1);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_tt_lock_detector
